// File: rtl/vdp_timing_gen.sv
// ---------------------------------------------------------------------------
// vdp_timing_gen
//
// Raster timing generator at the head of the VDP timing bus. A free-running
// horizontal counter (h) and vertical counter (v) advance on every pxclk edge.
// Their pre-edge values are decoded into registered sync, active, coordinate
// and start-pulse outputs. Every output therefore describes the same (h,v)
// one pxclk after the counters held it.
//
// The defaults give 1280x1024@60 with a 108 MHz pxclk. Other modes are selected
// through the parameters. Both totals must fit in 11 bits (<= 2048). A mode
// change requires a reset.
//
// Ports
//   pxclk        in   1   pixel clock, the only clock in the block
//   reset        in   1   synchronous, active-high reset
//   hsync        out  1   horizontal sync, asserted level = HS_POL
//   vsync        out  1   vertical sync, asserted level = VS_POL
//   col          out  11  raw horizontal counter h
//   row          out  10  raw vertical counter v, truncated to 10 bits
//   active       out  1   h < H_VIS and v < V_VIS
//   line_start   out  1   one-cycle pulse at h == 0
//   frame_start  out  1   one-cycle pulse at h == 0 and v == 0
// ---------------------------------------------------------------------------
module vdp_timing_gen #(
    parameter int unsigned H_VIS  = 1280,
    parameter int unsigned H_FP   = 48,
    parameter int unsigned H_SYNC = 112,
    parameter int unsigned H_BP   = 248,
    parameter int unsigned V_VIS  = 1024,
    parameter int unsigned V_FP   = 1,
    parameter int unsigned V_SYNC = 3,
    parameter int unsigned V_BP   = 38,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic        pxclk,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] col,
    output logic [9:0]  row,
    output logic        active,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Decode boundaries as 11-bit constants so every comparison is width-matched.
    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_END  = 11'(V_VIS);
    localparam logic [10:0] HS_START   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_VIS + V_FP + V_SYNC);

    logic [10:0] h_r;
    logic [10:0] v_r;
    logic [10:0] h_nxt_s;
    logic [10:0] v_nxt_s;
    logic        h_last_s;
    logic        v_last_s;
    logic        hs_win_s;
    logic        vs_win_s;
    logic        active_s;
    logic        line_start_s;
    logic        frame_start_s;

    assign h_last_s = (h_r == H_LAST);
    assign v_last_s = (v_r == V_LAST);

    // Next-state for the raster counters: v only moves when h wraps.
    always_comb begin
        h_nxt_s = h_r + 11'd1;
        v_nxt_s = v_r;
        if (h_last_s) begin
            h_nxt_s = 11'd0;
            if (v_last_s) begin
                v_nxt_s = 11'd0;
            end else begin
                v_nxt_s = v_r + 11'd1;
            end
        end else begin
            v_nxt_s = v_r;
        end
    end

    // Decode of the current (pre-edge) counter state into output values.
    // vsync follows v alone, so its edges land where v changes, i.e. at h == 0.
    always_comb begin
        hs_win_s      = (h_r >= HS_START) && (h_r < HS_END);
        vs_win_s      = (v_r >= VS_START) && (v_r < VS_END);
        active_s      = (h_r < H_VIS_END) && (v_r < V_VIS_END);
        line_start_s  = (h_r == 11'd0);
        frame_start_s = (h_r == 11'd0) && (v_r == 11'd0);
    end

    // Raster counters; reset restarts the frame at (0,0).
    always_ff @(posedge pxclk) begin
        if (reset) begin
            h_r <= 11'd0;
            v_r <= 11'd0;
        end else begin
            h_r <= h_nxt_s;
            v_r <= v_nxt_s;
        end
    end

    // Output register stage: one pxclk behind the counters, all fields aligned.
    // Reset forces the idle levels so no partial sync pulse survives a reset.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            col         <= 11'd0;
            row         <= 10'd0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_win_s ? HS_POL : ~HS_POL;
            vsync       <= vs_win_s ? VS_POL : ~VS_POL;
            col         <= h_r;
            row         <= v_r[9:0];
            active      <= active_s;
            line_start  <= line_start_s;
            frame_start <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_vdp_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vdp_timing_gen
//
// Two instances of vdp_timing_gen share one clock and reset:
//   dut_a: very short lines (8 pixels) with the full 1066-line vertical timing,
//          so a whole frame, the row truncation and the wrap fit in a short run.
//   dut_b: a small 60x30 mode with negative sync polarities.
// The reference model tracks only the number of pixels emitted since reset
// released and derives (h,v) and every output from the mode arithmetic.
// Randomly placed and sized reset pulses exercise mid-frame restarts.
// ---------------------------------------------------------------------------
module tb_vdp_timing_gen;

    // Mode A
    localparam int AHV = 4, AHF = 1, AHS = 2, AHB = 1;
    localparam int AVV = 1024, AVF = 1, AVS = 3, AVB = 38;
    localparam int A_FRAME = (AHV + AHF + AHS + AHB) * (AVV + AVF + AVS + AVB);
    // Mode B
    localparam int BHV = 40, BHF = 4, BHS = 6, BHB = 10;
    localparam int BVV = 20, BVF = 2, BVS = 3, BVB = 5;

    logic        pxclk;
    logic        reset;

    logic        hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
    logic [10:0] col_a;
    logic [9:0]  row_a;
    logic        hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
    logic [10:0] col_b;
    logic [9:0]  row_b;

    int checks;
    int errors;
    int pa;      // pixel index shown by dut_a outputs, -1 = reset values
    int pb;
    int nact;

    vdp_timing_gen #(
        .H_VIS(AHV), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_VIS(AVV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .pxclk(pxclk), .reset(reset),
        .hsync(hsync_a), .vsync(vsync_a), .col(col_a), .row(row_a),
        .active(active_a), .line_start(line_start_a), .frame_start(frame_start_a)
    );

    vdp_timing_gen #(
        .H_VIS(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_VIS(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .pxclk(pxclk), .reset(reset),
        .hsync(hsync_b), .vsync(vsync_b), .col(col_b), .row(row_b),
        .active(active_b), .line_start(line_start_b), .frame_start(frame_start_b)
    );

    initial pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at pa=%0d pb=%0d: got 0x%0h expected 0x%0h", tag, pa, pb, obs, exp);
        end
    endtask

    // Expected {hsync, vsync, col, row, active, line_start, frame_start} for pixel index p.
    function automatic logic [25:0] exp_vec(input int p,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb,
                                            input bit hp, input bit vp);
        int  ht, vt, h, v;
        bit  hsy, vsy;
        if (p < 0) begin
            return {~hp, ~vp, 11'd0, 10'd0, 3'b000};
        end
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        h   = p % ht;
        v   = (p / ht) % vt;
        hsy = ((h >= hv + hf) && (h < hv + hf + hs)) ? hp : ~hp;
        vsy = ((v >= vv + vf) && (v < vv + vf + vs)) ? vp : ~vp;
        return {hsy, vsy, 11'(h), 10'(v),
                ((h < hv) && (v < vv)), (h == 0), ((h == 0) && (v == 0))};
    endfunction

    // Advance one pxclk: update the model from the sampled reset, then compare on the falling edge.
    task automatic step();
        @(posedge pxclk);
        if (reset) begin
            pa = -1;
            pb = -1;
        end else begin
            pa++;
            pb++;
        end
        @(negedge pxclk);
        check_eq("dut_a_bus",
                 32'({hsync_a, vsync_a, col_a, row_a, active_a, line_start_a, frame_start_a}),
                 32'(exp_vec(pa, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 1'b1, 1'b1)));
        check_eq("dut_b_bus",
                 32'({hsync_b, vsync_b, col_b, row_b, active_b, line_start_b, frame_start_b}),
                 32'(exp_vec(pb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 1'b0, 1'b0)));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pa     = -1;
        pb     = -1;
        reset  = 1'b1;

        repeat (4) step();
        check_eq("reset_hsync_b", 32'(hsync_b), 32'd1);
        check_eq("reset_col_a", 32'(col_a), 32'd0);

        // First cycle after release shows (0,0).
        reset = 1'b0;
        step();
        check_eq("first_col", 32'(col_a), 32'd0);
        check_eq("first_row", 32'(row_a), 32'd0);
        check_eq("first_active", 32'(active_a), 32'd1);
        check_eq("first_ls", 32'(line_start_a), 32'd1);
        check_eq("first_fs", 32'(frame_start_a), 32'd1);
        check_eq("first_hsync", 32'(hsync_a), 32'd0);
        check_eq("first_vsync", 32'(vsync_a), 32'd0);

        // One full line of dut_b: active for exactly H_VIS cycles.
        nact = int'(active_b);
        repeat (BHV + BHF + BHS + BHB - 1) begin
            step();
            nact += int'(active_b);
        end
        check_eq("b_line_active", 32'(nact), 32'(BHV));

        // Run dut_a to the last pixel of the frame, then across the wrap.
        while (pa < A_FRAME - 1) step();
        check_eq("wrap_last_col", 32'(col_a), 32'd7);
        check_eq("wrap_last_row", 32'(row_a), 32'd41);
        step();
        check_eq("wrap_col", 32'(col_a), 32'd0);
        check_eq("wrap_row", 32'(row_a), 32'd0);
        check_eq("wrap_fs", 32'(frame_start_a), 32'd1);

        // Random mid-frame resets of random length.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 3000)) step();
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            check_eq("rst_active", 32'(active_a), 32'd0);
            reset = 1'b0;
            step();
            check_eq("rst_restart_fs", 32'(frame_start_a), 32'd1);
        end

        // A further uninterrupted frame including its wrap.
        repeat (A_FRAME + 100) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
